mux_2to1_4to1: RTL and testbench
================================

// Module: mux_2to1_4to1
// PURPOSE
//  Bit-select multiplexer primitives for the CPU datapath: 2:1 and 4:1 selectors, plus an
//  8:1 tree built from two 4:1 and one 2:1 stage. Each output is available combinationally
//  and as a registered copy. Used as the leaf cell of wider select trees: register-file read
//  ports, ALU result select, flag select.
// PARAMETERS
//  WIDTH   1   number of independent bit lanes per mux; lane k always uses sel lane-common
// PORTS
//  clk      in   1          rising-edge clock for registered outputs
//  reset    in   1          synchronous, active-high; clears registered outputs
//  en       in   1          register load enable for q2/q4/q8
//  in2      in   2*WIDTH    2:1 data; input j lane k at bit j*WIDTH+k
//  sel2     in   1          2:1 select
//  out2     out  WIDTH      combinational 2:1 result
//  in4      in   4*WIDTH    4:1 data; input j lane k at bit j*WIDTH+k
//  sel4     in   2          4:1 select
//  out4     out  WIDTH      combinational 4:1 result
//  in8      in   8*WIDTH    8:1 data; input j lane k at bit j*WIDTH+k
//  sel8     in   3          8:1 select
//  out8     out  WIDTH      combinational 8:1 result
//  q2       out  WIDTH      registered out2
//  q4       out  WIDTH      registered out4
//  q8       out  WIDTH      registered out8
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - Combinational outputs, zero latency, no clock dependence:
//    - out2[k] = in2[sel2*WIDTH+k].
//    - out4[k] = in4[sel4*WIDTH+k].
//    - out8[k] = in8[sel8*WIDTH+k].
//  - out8 structure:
//    - Lower 4:1 stage takes inputs 0-3 on sel8[1:0]; upper 4:1 stage takes inputs 4-7 on sel8[1:0].
//    - Final 2:1 stage picks the lower stage when sel8[2]=0 and the upper stage when sel8[2]=1.
//    - Result must equal the flat formula above for all 2048 {sel8,in8} values at WIDTH=1.
//  - Only 2:1 and 4:1 stages are used; each stage is a pure select (no priority, no latch).
//  - Registered outputs:
//    - On posedge clk: if reset, q2=q4=q8=0.
//    - Else if en, q2<=out2, q4<=out4, q8<=out8.
//    - Else hold.
//    - Reset overrides en.
//  - Output values:
//    - Registered outputs reset to 0.
//    - Combinational outputs are unaffected by reset.
//  - Latency: combinational outputs 0 cycles; registered outputs 1 cycle.
//  - X/Z on sel: the don't-care branch is not specified. A known sel with known selected data
//    must give a known output regardless of unselected inputs.
//  - Lanes are independent; sel is shared across all lanes.
// TESTING
//  - 2:1 exhaustive, WIDTH=1:
//    - Sweep {sel2,in2}=0..7, 10ns each -> out2=in2[sel2].
//    - e.g. sel2=1, in2=2'b10 -> out2=1.
//  - 4:1 exhaustive:
//    - Sweep {sel4,in4}=0..63 -> out4=in4[sel4].
//    - e.g. sel4=2, in4=4'b0100 -> 1; sel4=3, same in4 -> 0.
//  - 8:1 exhaustive:
//    - Sweep {sel8,in8}=0..2047, 10ns steps -> out8=in8[sel8].
//    - e.g. sel8=7, in8=8'h80 -> 1; sel8=3, in8=8'hF7 -> 0.
//  - Register path:
//    - en=1, sel8=5, in8=8'h20 -> q8 becomes 1 one clk after; out8 is 1 immediately.
//    - Drop en, change in8=0 -> q8 holds 1.
//  - Reset: assert reset with en=1 and out2=out4=out8=1 -> q2=q4=q8=0 at next edge;
//    out* stay 1; release reset -> q* reload on the following edge.
//  - WIDTH=4 lanes: in4=16'hDCBA, sel4=1 -> out4=4'hB; sel4=3 -> 4'hD.

Source files
------------

// File: rtl/mux_2to1_4to1_if.sv
// Bundle of select inputs, data inputs and mux results for the 2:1 / 4:1 / 8:1 selector cell.
// The master side drives data, selects and load enable; the slave side returns results.
interface mux_2to1_4to1_if #(
  parameter int WIDTH = 1
);
  logic               en;
  logic [2*WIDTH-1:0] in2;
  logic               sel2;
  logic [WIDTH-1:0]   out2;
  logic [4*WIDTH-1:0] in4;
  logic [1:0]         sel4;
  logic [WIDTH-1:0]   out4;
  logic [8*WIDTH-1:0] in8;
  logic [2:0]         sel8;
  logic [WIDTH-1:0]   out8;
  logic [WIDTH-1:0]   q2;
  logic [WIDTH-1:0]   q4;
  logic [WIDTH-1:0]   q8;

  modport master (
    output en, in2, sel2, in4, sel4, in8, sel8,
    input  out2, out4, out8, q2, q4, q8
  );

  modport slave (
    input  en, in2, sel2, in4, sel4, in8, sel8,
    output out2, out4, out8, q2, q4, q8
  );
endinterface

// File: rtl/mux_2to1_4to1.sv
// Lane-parallel 2:1, 4:1 and tree-built 8:1 selectors with combinational results and
// enable-gated registered copies. Input j of lane k lives at bit j*WIDTH+k.
module mux_2to1_4to1 #(
  parameter int WIDTH = 1
) (
  input logic                clk,
  input logic                reset,
  mux_2to1_4to1_if.slave     bus
);

  logic [WIDTH-1:0] out2_w;
  logic [WIDTH-1:0] out4_w;
  logic [WIDTH-1:0] out8_w;
  logic [WIDTH-1:0] q2_reg;
  logic [WIDTH-1:0] q4_reg;
  logic [WIDTH-1:0] q8_reg;

  // Pure selects: a known select with known chosen data never depends on the other inputs.
  function automatic logic mux2(input logic a0, input logic a1, input logic s);
    return s ? a1 : a0;
  endfunction

  function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
    return mux2(mux2(d[0], d[1], s[0]), mux2(d[2], d[3], s[0]), s[1]);
  endfunction

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic [3:0] d4;
    logic [3:0] lo_d;
    logic [3:0] hi_d;
    logic       lo_sel;
    logic       hi_sel;

    for (genvar gj = 0; gj < 4; gj++) begin : g_gather
      assign d4[gj]   = bus.in4[gj*WIDTH + gi];
      assign lo_d[gj] = bus.in8[gj*WIDTH + gi];
      assign hi_d[gj] = bus.in8[(gj+4)*WIDTH + gi];
    end

    assign out2_w[gi] = mux2(bus.in2[gi], bus.in2[WIDTH + gi], bus.sel2);
    assign out4_w[gi] = mux4(d4, bus.sel4);

    // 8:1 is two 4:1 stages on sel8[1:0] feeding a 2:1 stage on sel8[2].
    assign lo_sel     = mux4(lo_d, bus.sel8[1:0]);
    assign hi_sel     = mux4(hi_d, bus.sel8[1:0]);
    assign out8_w[gi] = mux2(lo_sel, hi_sel, bus.sel8[2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q2_reg <= '0;
      q4_reg <= '0;
      q8_reg <= '0;
    end else if (bus.en) begin
      q2_reg <= out2_w;
      q4_reg <= out4_w;
      q8_reg <= out8_w;
    end
  end

  assign bus.out2 = out2_w;
  assign bus.out4 = out4_w;
  assign bus.out8 = out8_w;
  assign bus.q2   = q2_reg;
  assign bus.q4   = q4_reg;
  assign bus.q8   = q8_reg;

endmodule

// File: tb/tb_mux_2to1_4to1.sv
// Self-checking bench: exhaustive selector sweeps at WIDTH=1, lane checks and randomized
// register-path checks at WIDTH=4, all against a shift-and-mask reference model.
module tb_mux_2to1_4to1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_2to1_4to1_if #(.WIDTH(1)) b1 ();
  mux_2to1_4to1_if #(.WIDTH(4)) b4 ();

  mux_2to1_4to1 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  mux_2to1_4to1 #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

  int checks = 0;
  int errors = 0;

  // Reference: select input number sel out of a packed word of w-bit inputs.
  function automatic logic [3:0] pick(input logic [31:0] data, input int sel, input int w);
    logic [31:0] t;
    logic [31:0] m;
    t = data >> (sel * w);
    m = (32'd1 << w) - 32'd1;
    return t[3:0] & m[3:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    b1.en = 1'b1; b4.en = 1'b1;
    b1.in2 = '1; b1.in4 = '1; b1.in8 = '1;
    b4.in2 = '1; b4.in4 = '1; b4.in8 = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b1.q2, b1.q4, b1.q8} !== 3'b000) begin
      errors++;
      $display("FAIL reset_w1: q2/q4/q8=%b required 000", {b1.q2, b1.q4, b1.q8});
    end
    checks++;
    if ({b4.q2, b4.q4, b4.q8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w4: q2/q4/q8=%h required 000", {b4.q2, b4.q4, b4.q8});
    end
    $display("reset: q outputs checked at zero");
    @(negedge clk);
    reset = 1'b0;
    b1.en = 1'b0; b4.en = 1'b0;
  endtask

  task automatic test_mux2();
    logic [2:0] v;
    logic       exp;
    int         bad = 0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      b1.sel2 = v[2];
      b1.in2  = v[1:0];
      #10;
      exp = pick(32'(v[1:0]), int'(v[2]), 1) != 4'd0;
      checks++;
      if (b1.out2 !== exp) begin
        errors++; bad++;
        $display("FAIL mux2 sel2=%0d in2=%b: out2=%b required %b", v[2], v[1:0], b1.out2, exp);
      end
    end
    $display("mux2 sweep: 8 cases, %0d bad", bad);
  endtask

  task automatic test_mux4();
    logic [5:0] v;
    logic       exp;
    int         bad = 0;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      b1.sel4 = v[5:4];
      b1.in4  = v[3:0];
      #10;
      exp = pick(32'(v[3:0]), int'(v[5:4]), 1) != 4'd0;
      checks++;
      if (b1.out4 !== exp) begin
        errors++; bad++;
        $display("FAIL mux4 sel4=%0d in4=%b: out4=%b required %b", v[5:4], v[3:0], b1.out4, exp);
      end
    end
    $display("mux4 sweep: 64 cases, %0d bad", bad);
  endtask

  task automatic test_mux8();
    logic [10:0] v;
    logic        exp;
    int          bad = 0;
    for (int i = 0; i < 2048; i++) begin
      v = 11'(i);
      b1.sel8 = v[10:8];
      b1.in8  = v[7:0];
      #10;
      exp = pick(32'(v[7:0]), int'(v[10:8]), 1) != 4'd0;
      checks++;
      if (b1.out8 !== exp) begin
        errors++; bad++;
        $display("FAIL mux8 sel8=%0d in8=%h: out8=%b required %b", v[10:8], v[7:0], b1.out8, exp);
      end
    end
    $display("mux8 sweep: 2048 cases, %0d bad", bad);
  endtask

  task automatic test_register_path();
    @(negedge clk);
    b1.en = 1'b1; b1.sel8 = 3'd5; b1.in8 = 8'h20;
    #1;
    checks++;
    if (b1.out8 !== 1'b1) begin
      errors++;
      $display("FAIL regpath_comb: out8=%b required 1", b1.out8);
    end
    @(posedge clk); #1;
    checks++;
    if (b1.q8 !== 1'b1) begin
      errors++;
      $display("FAIL regpath_load: q8=%b required 1", b1.q8);
    end
    @(negedge clk);
    b1.en = 1'b0; b1.in8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b1.q8 !== 1'b1 || b1.out8 !== 1'b0) begin
      errors++;
      $display("FAIL regpath_hold: q8=%b out8=%b required q8=1 out8=0", b1.q8, b1.out8);
    end
    $display("register path: load and hold checked");
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    b1.en = 1'b1;
    b1.sel2 = 1'b0; b1.in2 = 2'b01;
    b1.sel4 = 2'd2; b1.in4 = 4'b0100;
    b1.sel8 = 3'd7; b1.in8 = 8'h80;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b1.q2, b1.q4, b1.q8} !== 3'b000) begin
      errors++;
      $display("FAIL rst_override_q: q2/q4/q8=%b required 000", {b1.q2, b1.q4, b1.q8});
    end
    checks++;
    if ({b1.out2, b1.out4, b1.out8} !== 3'b111) begin
      errors++;
      $display("FAIL rst_override_out: out2/4/8=%b required 111", {b1.out2, b1.out4, b1.out8});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({b1.q2, b1.q4, b1.q8} !== 3'b111) begin
      errors++;
      $display("FAIL rst_release_reload: q2/q4/q8=%b required 111", {b1.q2, b1.q4, b1.q8});
    end
    @(negedge clk);
    b1.en = 1'b0;
    $display("reset override: clear then reload checked");
  endtask

  task automatic test_unselected_x();
    b1.sel2 = 1'b0; b1.in2 = 2'bx1;
    b1.sel8 = 3'd3; b1.in8 = 8'bxxxx0xxx;
    #1;
    checks++;
    if (b1.out2 !== 1'b1 || b1.out8 !== 1'b0) begin
      errors++;
      $display("FAIL unselected_x: out2=%b out8=%b required out2=1 out8=0", b1.out2, b1.out8);
    end
    b1.in8 = 8'hF7;
    #1;
    checks++;
    if (b1.out8 !== 1'b0) begin
      errors++;
      $display("FAIL mux8_f7: out8=%b required 0", b1.out8);
    end
    $display("unselected-input independence checked");
  endtask

  task automatic test_lanes();
    b4.in4 = 16'hDCBA;
    b4.sel4 = 2'd1;
    #1;
    checks++;
    if (b4.out4 !== 4'hB) begin
      errors++;
      $display("FAIL lanes_sel1: out4=%h required b", b4.out4);
    end
    b4.sel4 = 2'd3;
    #1;
    checks++;
    if (b4.out4 !== 4'hD) begin
      errors++;
      $display("FAIL lanes_sel3: out4=%h required d", b4.out4);
    end
    $display("WIDTH=4 lanes: in4=dcba checked for sel4=1 and 3");
  endtask

  task automatic test_random_registered();
    logic [3:0] m2 = '0, m4 = '0, m8 = '0;
    logic [3:0] e2, e4, e8;
    int         bad = 0;
    // start from a known registered state
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 15) == 0);
      b4.en   = 1'($urandom_range(0, 1));
      b4.in2  = 8'($urandom);
      b4.in4  = 16'($urandom);
      b4.in8  = 32'($urandom);
      b4.sel2 = 1'($urandom);
      b4.sel4 = 2'($urandom);
      b4.sel8 = 3'($urandom);
      e2 = pick(32'(b4.in2), int'(b4.sel2), 4);
      e4 = pick(32'(b4.in4), int'(b4.sel4), 4);
      e8 = pick(b4.in8, int'(b4.sel8), 4);
      #1;
      checks++;
      if ({b4.out2, b4.out4, b4.out8} !== {e2, e4, e8}) begin
        errors++; bad++;
        $display("FAIL rand_comb[%0d]: out2/4/8=%h required %h", i, {b4.out2, b4.out4, b4.out8}, {e2, e4, e8});
      end
      @(posedge clk);
      if (reset) begin
        m2 = '0; m4 = '0; m8 = '0;
      end else if (b4.en) begin
        m2 = e2; m4 = e4; m8 = e8;
      end
      #1;
      checks++;
      if ({b4.q2, b4.q4, b4.q8} !== {m2, m4, m8}) begin
        errors++; bad++;
        $display("FAIL rand_reg[%0d]: q2/q4/q8=%h required %h (reset=%b en=%b)", i, {b4.q2, b4.q4, b4.q8}, {m2, m4, m8}, reset, b4.en);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    $display("random registered traffic: 400 cycles, %0d bad", bad);
  endtask

  initial begin
    b1.en = 1'b0; b1.in2 = '0; b1.sel2 = 1'b0; b1.in4 = '0; b1.sel4 = '0; b1.in8 = '0; b1.sel8 = '0;
    b4.en = 1'b0; b4.in2 = '0; b4.sel2 = 1'b0; b4.in4 = '0; b4.sel4 = '0; b4.in8 = '0; b4.sel8 = '0;
    test_reset();
    test_mux2();
    test_mux4();
    test_mux8();
    test_register_path();
    test_reset_override();
    test_unselected_x();
    test_lanes();
    test_random_registered();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
